// File: rtl/ws2812b_receiver_if.sv
// Serial line in, decoded pixel/frame strobes and colour bytes out.
// The receiver drives through master; the consumer (or bench) attaches to slave.
interface ws2812b_receiver_if #(
  parameter int AW = 2
);
  logic          DI;
  logic [AW-1:0] address;
  logic [7:0]    green_out;
  logic [7:0]    red_out;
  logic [7:0]    blue_out;
  logic          pixel_valid;
  logic          frame_done;
  logic          error;

  modport master (
    input  DI,
    output address, green_out, red_out, blue_out, pixel_valid, frame_done, error
  );

  modport slave (
    output DI,
    input  address, green_out, red_out, blue_out, pixel_valid, frame_done, error
  );
endinterface

// File: rtl/ws2812b_receiver.sv
// WS2812B chain decoder: bit decided 3 cycles after DI falls, pixel strobe one cycle after the 24th bit.
// No backpressure: pixel_valid/frame_done are single-cycle strobes the consumer must take when they fire.
module ws2812b_receiver #(
  parameter int NUM_LEDS     = 4,
  parameter int SYSTEM_CLOCK = 50_000_000
) (
  input logic                clk,
  input logic                reset,
  ws2812b_receiver_if.master bus
);

  localparam int CYCLE_COUNT   = SYSTEM_CLOCK / 800000;
  localparam int BIT_THRESHOLD = CYCLE_COUNT / 2;
  localparam int GLITCH_COUNT  = CYCLE_COUNT / 8;
  localparam int HIGH_TIMEOUT  = 2 * CYCLE_COUNT;
  localparam int LATCH_COUNT   = 40 * CYCLE_COUNT;

  localparam int LW = $clog2(LATCH_COUNT + 1);
  localparam int HW = $clog2(HIGH_TIMEOUT + 1);
  localparam int AW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  // LED index needs one extra code to represent "chain full"
  localparam int IW = $clog2(NUM_LEDS + 1);

  localparam logic [LW-1:0] LATCH_L   = LW'(LATCH_COUNT);
  localparam logic [HW-1:0] TIMEOUT_H = HW'(HIGH_TIMEOUT);
  localparam logic [HW-1:0] THRESH_H  = HW'(BIT_THRESHOLD);
  localparam logic [HW-1:0] GLITCH_H  = HW'(GLITCH_COUNT);
  localparam logic [IW-1:0] NUM_I     = IW'(NUM_LEDS);

  typedef enum logic [1:0] {LOCKOUT, ARMED, HIGH, LOW} state_t;

  state_t        state_q, state_d;
  logic          sync_q, di_s_q, di_prev_q;
  logic [LW-1:0] low_cnt_q, low_cnt_d, low_inc;
  logic [HW-1:0] high_cnt_q, high_cnt_d, high_inc;
  logic [23:0]   shift_q, shift_d;
  logic [4:0]    bit_cnt_q, bit_cnt_d;
  logic [IW-1:0] led_idx_q, led_idx_d;
  logic          pend_q, pend_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [7:0]    green_q, green_d, red_q, red_d, blue_q, blue_d;
  logic          pixel_valid_q, pixel_valid_d;
  logic          frame_done_q, frame_done_d;
  logic          error_q, error_d;
  logic          rise, fall, bit_val;

  assign rise     = di_s_q & ~di_prev_q;
  assign fall     = ~di_s_q & di_prev_q;
  assign low_inc  = (low_cnt_q == LATCH_L) ? LATCH_L : low_cnt_q + 1'b1;
  assign high_inc = (high_cnt_q == TIMEOUT_H) ? TIMEOUT_H : high_cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    low_cnt_d     = low_cnt_q;
    high_cnt_d    = high_cnt_q;
    shift_d       = shift_q;
    bit_cnt_d     = bit_cnt_q;
    led_idx_d     = led_idx_q;
    pend_d        = 1'b0;
    addr_d        = addr_q;
    green_d       = green_q;
    red_d         = red_q;
    blue_d        = blue_q;
    pixel_valid_d = 1'b0;
    frame_done_d  = 1'b0;
    error_d       = error_q;
    bit_val       = 1'b0;

    // Completed pixel from the previous cycle: publish it or drop it if the chain is full
    if (pend_q) begin
      if (led_idx_q < NUM_I) begin
        addr_d        = led_idx_q[AW-1:0];
        green_d       = shift_q[23:16];
        red_d         = shift_q[15:8];
        blue_d        = shift_q[7:0];
        pixel_valid_d = 1'b1;
        led_idx_d     = led_idx_q + 1'b1;
      end else begin
        error_d = 1'b1;
      end
    end

    case (state_q)
      LOCKOUT: begin
        if (di_s_q) begin
          low_cnt_d = '0;
        end else if (low_inc == LATCH_L) begin
          state_d   = ARMED;
          low_cnt_d = '0;
          led_idx_d = '0;
          bit_cnt_d = '0;
          addr_d    = '0;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      ARMED: begin
        if (rise) begin
          high_cnt_d = '0;
          state_d    = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          low_cnt_d = '0;
          state_d   = LOW;
          if (high_cnt_q < GLITCH_H) begin
            error_d = 1'b1;
          end else begin
            bit_val = (high_cnt_q >= THRESH_H);
            shift_d = {shift_q[22:0], bit_val};
            if (bit_cnt_q == 5'd23) begin
              bit_cnt_d = '0;
              pend_d    = 1'b1;
            end else begin
              bit_cnt_d = bit_cnt_q + 1'b1;
            end
          end
        end else begin
          high_cnt_d = high_inc;
          if (high_inc == TIMEOUT_H) begin
            error_d   = 1'b1;
            low_cnt_d = '0;
            state_d   = LOCKOUT;
          end
        end
      end
      LOW: begin
        if (rise) begin
          high_cnt_d = '0;
          state_d    = HIGH;
        end else if (low_inc == LATCH_L) begin
          // Latch: a partially received pixel is thrown away and flagged
          frame_done_d = 1'b1;
          state_d      = ARMED;
          low_cnt_d    = '0;
          led_idx_d    = '0;
          addr_d       = '0;
          bit_cnt_d    = '0;
          shift_d      = '0;
          if (bit_cnt_q != 5'd0) error_d = 1'b1;
        end else begin
          low_cnt_d = low_inc;
        end
      end
      default: state_d = LOCKOUT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= LOCKOUT;
      sync_q        <= 1'b0;
      di_s_q        <= 1'b0;
      di_prev_q     <= 1'b0;
      low_cnt_q     <= '0;
      high_cnt_q    <= '0;
      shift_q       <= '0;
      bit_cnt_q     <= '0;
      led_idx_q     <= '0;
      pend_q        <= 1'b0;
      addr_q        <= '0;
      green_q       <= '0;
      red_q         <= '0;
      blue_q        <= '0;
      pixel_valid_q <= 1'b0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync_q        <= bus.DI;
      di_s_q        <= sync_q;
      di_prev_q     <= di_s_q;
      low_cnt_q     <= low_cnt_d;
      high_cnt_q    <= high_cnt_d;
      shift_q       <= shift_d;
      bit_cnt_q     <= bit_cnt_d;
      led_idx_q     <= led_idx_d;
      pend_q        <= pend_d;
      addr_q        <= addr_d;
      green_q       <= green_d;
      red_q         <= red_d;
      blue_q        <= blue_d;
      pixel_valid_q <= pixel_valid_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
    end
  end

  assign bus.address     = addr_q;
  assign bus.green_out   = green_q;
  assign bus.red_out     = red_q;
  assign bus.blue_out    = blue_q;
  assign bus.pixel_valid = pixel_valid_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.error       = error_q;

endmodule

// File: tb/tb_ws2812b_receiver.sv
// Directed bench for ws2812b_receiver at 50 MHz, 4 LEDs; pixel expectations flow through a scoreboard queue.
module tb_ws2812b_receiver;

  logic clk;
  logic reset;

  ws2812b_receiver_if #(.AW(2)) bus ();

  ws2812b_receiver #(.NUM_LEDS(4), .SYSTEM_CLOCK(50_000_000)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [1:0]  addr;
    logic [23:0] grb;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   n_fail  = 0;
  int   pv_cnt  = 0;
  int   fd_cnt  = 0;
  logic fd_prev = 1'b0;
  logic fd_long = 1'b0;
  logic both_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.pixel_valid && bus.frame_done) both_seen = 1'b1;
    if (bus.frame_done && fd_prev) fd_long = 1'b1;
    fd_prev = bus.frame_done;
    if (bus.frame_done) fd_cnt++;
    if (bus.pixel_valid) begin
      pv_cnt++;
      if (sb.size() == 0) begin
        check("pv_unexpected", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        check("pixel", {6'd0, bus.address, bus.green_out, bus.red_out, bus.blue_out}, {6'd0, e});
      end
    end
  end

  // Level held for exactly n clock cycles; transitions land 1ns after a rising edge
  task automatic drive(input logic v, input int n);
    bus.DI = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    if (b) begin
      drive(1'b1, 39);
      drive(1'b0, 23);
    end else begin
      drive(1'b1, 19);
      drive(1'b0, 43);
    end
  endtask

  task automatic send_led(input logic [7:0] g, input logic [7:0] r, input logic [7:0] b);
    logic [23:0] w;
    w = {g, r, b};
    for (int i = 23; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_bits(input logic [23:0] w, input int n);
    for (int i = 23; i > 23 - n; i--) send_bit(w[i]);
  endtask

  task automatic do_reset();
    bus.DI = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int pv0, fd0;
    bus.DI = 1'b0;
    reset  = 1'b1;
    repeat (3) @(posedge clk);
    #3;
    check("rst_colours", {8'd0, bus.green_out, bus.red_out, bus.blue_out}, 32'd0);
    check("rst_strobes", {29'd0, bus.pixel_valid, bus.frame_done, bus.error}, 32'd0);
    check("rst_address", {30'd0, bus.address}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Single LED after an initial latch period
    drive(1'b0, 2480);
    pv0 = pv_cnt; fd0 = fd_cnt;
    sb.push_back({2'd0, 24'hA53CFF});
    send_led(8'hA5, 8'h3C, 8'hFF);
    drive(1'b0, 100);
    check("one_led_pv", pv_cnt - pv0, 1);
    check("one_led_err", {31'd0, bus.error}, 32'd0);
    drive(1'b0, 2600);
    check("one_led_fd", fd_cnt - fd0, 1);

    // Full chain of four
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int k = 1; k <= 4; k++) begin
      sb.push_back({2'(k - 1), {3{8'(k)}}});
      send_led(8'(k), 8'(k), 8'(k));
    end
    drive(1'b0, 2600);
    check("chain4_pv", pv_cnt - pv0, 4);
    check("chain4_fd", fd_cnt - fd0, 1);
    check("chain4_err", {31'd0, bus.error}, 32'd0);
    check("chain4_sb", 32'(sb.size()), 32'd0);

    // Five LEDs into a four-LED chain
    pv0 = pv_cnt; fd0 = fd_cnt;
    for (int k = 0; k < 5; k++) begin
      if (k < 4) sb.push_back({2'(k), {3{8'h11 + 8'(k)}}});
      send_led(8'h11 + 8'(k), 8'h11 + 8'(k), 8'h11 + 8'(k));
    end
    drive(1'b0, 2600);
    check("over_pv", pv_cnt - pv0, 4);
    check("over_fd", fd_cnt - fd0, 1);
    check("over_err", {31'd0, bus.error}, 32'd1);
    check("over_hold", {8'd0, bus.green_out, bus.red_out, bus.blue_out}, 32'h00141414);
    check("over_addr", {30'd0, bus.address}, 32'd0);

    // Partial pixel before latch
    do_reset();
    drive(1'b0, 2480);
    pv0 = pv_cnt; fd0 = fd_cnt;
    send_bits(24'hFFF000, 12);
    drive(1'b0, 2600);
    check("partial_pv", pv_cnt - pv0, 0);
    check("partial_fd", fd_cnt - fd0, 1);
    check("partial_err", {31'd0, bus.error}, 32'd1);
    pv0 = pv_cnt;
    sb.push_back({2'd0, 24'h5A0F81});
    send_led(8'h5A, 8'h0F, 8'h81);
    drive(1'b0, 100);
    check("partial_next_pv", pv_cnt - pv0, 1);

    // Glitch then stuck-high pulse
    do_reset();
    drive(1'b0, 2480);
    pv0 = pv_cnt;
    drive(1'b1, 4);
    drive(1'b0, 30);
    check("glitch_err", {31'd0, bus.error}, 32'd1);
    drive(1'b1, 150);
    drive(1'b0, 100);
    send_led(8'hC3, 8'h3C, 8'h99);
    drive(1'b0, 100);
    check("lockout_pv", pv_cnt - pv0, 0);
    drive(1'b0, 2480);
    sb.push_back({2'd0, 24'h017E80});
    send_led(8'h01, 8'h7E, 8'h80);
    drive(1'b0, 100);
    check("resume_pv", pv_cnt - pv0, 1);

    // Reset in the middle of a pixel
    do_reset();
    drive(1'b0, 2480);
    pv0 = pv_cnt;
    sb.push_back({2'd0, 24'hDEAD42});
    send_led(8'hDE, 8'hAD, 8'h42);
    send_bits(24'hFFFFFF, 10);
    reset = 1'b1;
    #2;
    check("async_colours", {8'd0, bus.green_out, bus.red_out, bus.blue_out}, 32'd0);
    check("async_strobes", {29'd0, bus.pixel_valid, bus.frame_done, bus.error}, 32'd0);
    bus.DI = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("midrst_pv", pv_cnt - pv0, 1);
    drive(1'b0, 2480);
    sb.push_back({2'd0, 24'h24BD66});
    send_led(8'h24, 8'hBD, 8'h66);
    drive(1'b0, 100);
    check("after_rst_pv", pv_cnt - pv0, 2);

    check("sb_empty", 32'(sb.size()), 32'd0);
    check("fd_one_cycle", {31'd0, fd_long}, 32'd0);
    check("pv_fd_exclusive", {31'd0, both_seen}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
